traffic_sequencer: RTL

Phase sequencer for the intersection controller. It owns a 16-entry phase table and steps through phases 0..`limit` with a per-phase countdown in seconds. It drives the 10 lamp outputs, including flicker, and the greenman enable. It also supports pause, manual skip and runtime table writes from the edit/debounce front end. It sits between the oneshot/debounce inputs and the lamp, greenman and seg_decode outputs.

---
 rtl/traffic_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: steps a 16-entry phase table with per-phase second countdown, lamp flicker and greenman.
module traffic_sequencer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_TICKS   = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        en,
  input  logic        stop,
  input  logic        next,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [26:0] cfg_wdata,
  input  logic        limit_we,
  input  logic [3:0]  limit_wdata,
  output logic [3:0]  phase,
  output logic [5:0]  remain,
  output logic [9:0]  lights,
  output logic        greenman,
  output logic        phase_start,
  output logic        paused
);
  localparam int SW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(BLINK_TICKS);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [26:0] tbl_q [16];
  logic [26:0] ent_d;
  logic [3:0] limit_q, phase_q, phase_d, nxt_idx;
  logic [5:0] remain_q, remain_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_q, blink_d, load, sec_stb, blink_wrap;
  logic [9:0] lights_q, lights_d;
  logic greenman_q, greenman_d, start_q, paused_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    remain_d = remain_q;
    sec_cnt_d = sec_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d = blink_q;
    load = 1'b0;
    sec_stb = state_q == RUN && tick && sec_cnt_q == SW'(TICKS_PER_SEC - 1);
    blink_wrap = blink_cnt_q == BW'(BLINK_TICKS - 1);
    nxt_idx = (phase_q >= limit_q) ? 4'd0 : phase_q + 4'd1;
    if (!en) begin
      state_d = IDLE;
      phase_d = '0;
      remain_d = '0;
      sec_cnt_d = '0;
      blink_cnt_d = '0;
      blink_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
      phase_d = '0;
      load = 1'b1;
    end else begin
      if (tick) begin
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_d = blink_q ^ blink_wrap;
      end
      if (state_q == RUN && tick) sec_cnt_d = sec_stb ? '0 : sec_cnt_q + 1'b1;
      if (sec_stb && remain_q > 6'd1) remain_d = remain_q - 6'd1;
      if (next || (sec_stb && remain_q <= 6'd1)) begin
        phase_d = nxt_idx;
        load = 1'b1;
      end
      state_d = stop ? PAUSE : RUN;
    end
    // write-through so a same-cycle table write is seen by the load and the lamps
    ent_d = (cfg_we && cfg_addr == phase_d) ? cfg_wdata : tbl_q[phase_d];
    if (load) begin
      remain_d = (ent_d[25:20] == 6'd0) ? 6'd1 : ent_d[25:20];
      sec_cnt_d = '0;
      blink_cnt_d = '0;
      blink_d = 1'b0;
    end
    lights_d = (state_d == IDLE) ? 10'd0 : blink_d ? ent_d[19:10] : ent_d[9:0];
    greenman_d = state_d != IDLE && ent_d[26];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
      limit_q <= '0;
    end else begin
      if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
      if (limit_we) limit_q <= limit_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      remain_q <= '0;
      sec_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_q <= 1'b0;
      lights_q <= '0;
      greenman_q <= 1'b0;
      start_q <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      remain_q <= remain_d;
      sec_cnt_q <= sec_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
      lights_q <= lights_d;
      greenman_q <= greenman_d;
      start_q <= load;
      paused_q <= state_d == PAUSE;
    end
  end
  assign phase = phase_q;
  assign remain = remain_q;
  assign lights = lights_q;
  assign greenman = greenman_q;
  assign phase_start = start_q;
  assign paused = paused_q;
endmodule
